// File: rtl/bm_uart_tx.sv
// Bus-monitor UART transmitter.
// Buffers 32-bit monitor words in a FIFO and sends each one as a six-byte
// 8N1 packet on tx_bm: SYNC_BYTE, data[31:24], data[23:16], data[15:8],
// data[7:0], checksum (sum of the four data bytes mod 256).
// Words that arrive while the FIFO is full are dropped and counted in a
// saturating overflow counter. The monitor is never back-pressured.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | line high, waiting for a buffered word and tx_en
// START | start bit (0) of the current byte, CLK_DIV cycles
// DATA  | data bits, LSB first, CLK_DIV cycles each
// STOP  | stop bit (1); then next byte, next packet, or back to IDLE
module bm_uart_tx #(
    parameter int         CLK_DIV    = 100,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [31:0] bm_data,
    input  logic        bm_vld,
    input  logic        tx_en,
    output logic        tx_bm,
    output logic        busy,
    output logic [8:0]  fifo_lvl,
    output logic [7:0]  ovf_cnt
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [8:0]  LVL_FULL  = 9'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [15:0]   baud_cnt, baud_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [2:0]    byte_idx, byte_nxt;
    logic          tx_q, tx_nxt;
    logic          busy_q, busy_nxt;
    logic [31:0]   word_q;
    logic [7:0]    csum_q;
    logic [7:0]    cur_byte;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   head;
    logic [7:0]    head_sum;
    logic          pop, push;
    logic          can_start;
    logic          baud_tc;

    assign head      = mem[rd_ptr];
    assign head_sum  = head[31:24] + head[23:16] + head[15:8] + head[7:0];
    assign can_start = (fifo_lvl != 9'd0) && tx_en;
    assign baud_tc   = (baud_cnt == BAUD_LAST);
    // A full FIFO still takes a word on the edge that frees a slot.
    assign push      = bm_vld && ((fifo_lvl < LVL_FULL) || pop);

    assign tx_bm = tx_q;
    assign busy  = busy_q;

    // FIFO storage; no reset so it can map onto distributed RAM.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= bm_data;
        end
    end

    // FIFO pointers, occupancy and saturating drop counter.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_lvl <= 9'd0;
            ovf_cnt  <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_lvl <= fifo_lvl + 9'd1;
                2'b01:   fifo_lvl <= fifo_lvl - 9'd1;
                default: fifo_lvl <= fifo_lvl;
            endcase
            if (bm_vld && !push && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
        end
    end

    // Byte currently on the line, selected by packet position.
    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = word_q[31:24];
            3'd2:    cur_byte = word_q[23:16];
            3'd3:    cur_byte = word_q[15:8];
            3'd4:    cur_byte = word_q[7:0];
            3'd5:    cur_byte = csum_q;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // FSM state register plus the counters and registered line output.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 3'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            word_q   <= 32'd0;
            csum_q   <= 8'd0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            tx_q     <= tx_nxt;
            busy_q   <= busy_nxt;
            if (pop) begin
                word_q <= head;
                csum_q <= head_sum;
            end
        end
    end

    // Next-state, counter and line-level decode; tx_nxt is the level for
    // the bit that begins on the coming edge.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        tx_nxt    = tx_q;
        busy_nxt  = busy_q;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                baud_nxt = 16'd0;
                tx_nxt   = 1'b1;
                if (can_start) begin
                    pop       = 1'b1;
                    state_nxt = START;
                    byte_nxt  = 3'd0;
                    bit_nxt   = 3'd0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (baud_tc) begin
                    baud_nxt  = 16'd0;
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                    tx_nxt    = cur_byte[0];
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_tc) begin
                    baud_nxt = 16'd0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        bit_nxt   = 3'd0;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = cur_byte[bit_idx + 3'd1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_tc) begin
                    baud_nxt = 16'd0;
                    if (byte_idx < 3'd5) begin
                        byte_nxt  = byte_idx + 3'd1;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else if (can_start) begin
                        pop       = 1'b1;
                        byte_nxt  = 3'd0;
                        state_nxt = START;
                        tx_nxt    = 1'b0;
                    end else begin
                        byte_nxt  = 3'd0;
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end else begin
                    baud_nxt = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bm_uart_tx.sv
// Directed bench for bm_uart_tx with CLK_DIV=4, FIFO_DEPTH=16.
module tb_bm_uart_tx;

    localparam int CLK_DIV = 4;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] bm_data;
    logic        bm_vld;
    logic        tx_en;
    logic        tx_bm;
    logic        busy;
    logic [8:0]  fifo_lvl;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    logic busy_d = 1'b0;

    bm_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .bm_data  (bm_data),
        .bm_vld   (bm_vld),
        .tx_en    (tx_en),
        .tx_bm    (tx_bm),
        .busy     (busy),
        .fifo_lvl (fifo_lvl),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // Edge counter: after posedge k, cyc == k.
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Record the edges on which busy rises and falls.
    always @(negedge clk_sys) begin
        if (busy === 1'b1 && busy_d === 1'b0) rise_cyc = cyc;
        if (busy === 1'b0 && busy_d === 1'b1) fall_cyc = cyc;
        busy_d = busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] make_pkt(input logic [31:0] w);
        logic [7:0] s;
        s = w[31:24] + w[23:16] + w[15:8] + w[7:0];
        return {8'hA5, w, s};
    endfunction

    // Called at a negedge; drives one word for exactly one posedge.
    task automatic push(input logic [31:0] w);
        bm_data = w;
        bm_vld  = 1'b1;
        @(negedge clk_sys);
        bm_vld  = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then samples all 60 bits near mid-bit.
    task automatic rx_packet(output logic [47:0] pkt, output bit ok, output int t0);
        int n;
        logic [7:0] b;
        pkt = '0;
        ok  = 1'b1;
        n   = 0;
        b   = '0;
        while (tx_bm !== 1'b0 && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        t0 = cyc;
        if (tx_bm !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        @(negedge clk_sys);
        for (int by = 0; by < 6; by++) begin
            if (tx_bm !== 1'b0) ok = 1'b0;
            for (int bi = 0; bi < 8; bi++) begin
                repeat (CLK_DIV) @(negedge clk_sys);
                b[bi] = tx_bm;
            end
            repeat (CLK_DIV) @(negedge clk_sys);
            if (tx_bm !== 1'b1) ok = 1'b0;
            pkt = {pkt[39:0], b};
            if (by < 5) repeat (CLK_DIV) @(negedge clk_sys);
        end
    endtask

    initial begin
        logic [47:0] pkt;
        bit          ok;
        int          t0;
        int          t_prev;
        int          push_cyc;
        bit          quiet;
        logic [31:0] exp_w [17];

        rst     = 1'b1;
        bm_data = 32'd0;
        bm_vld  = 1'b0;
        tx_en   = 1'b1;
        #1;
        check("rst_tx", tx_bm, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_lvl", fifo_lvl, 9'd0);
        check("rst_ovf", ovf_cnt, 8'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        repeat (3) @(negedge clk_sys);

        // 1: single word, exact latency and busy length
        push(32'h12345678);
        push_cyc = cyc;
        check("t1_tx_high_at_push", tx_bm, 1'b1);
        rx_packet(pkt, ok, t0);
        check("t1_frame", ok, 1'b1);
        check("t1_pkt", pkt, 48'hA5_12345678_14);
        check("t1_latency", t0 - push_cyc, 1);
        repeat (10) @(negedge clk_sys);
        check("t1_busy_len", fall_cyc - rise_cyc, 240);
        check("t1_busy_rise", rise_cyc, t0);
        check("t1_idle_tx", tx_bm, 1'b1);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_lvl", fifo_lvl, 9'd0);

        // 2: burst of 20 words into an idle block
        fork
            begin
                for (int i = 0; i < 20; i++) push(32'hC0DE_0000 + i);
                check("t2_lvl_full", fifo_lvl, 9'd16);
                check("t2_ovf", ovf_cnt, 8'd3);
            end
            begin
                t_prev = 0;
                for (int k = 0; k < 17; k++) begin
                    rx_packet(pkt, ok, t0);
                    check("t2_frame", ok, 1'b1);
                    check("t2_pkt", pkt, make_pkt(32'hC0DE_0000 + k));
                    if (k > 0) check("t2_gap", t0 - t_prev, 240);
                    t_prev = t0;
                end
            end
        join
        repeat (10) @(negedge clk_sys);
        check("t2_end_busy", busy, 1'b0);
        check("t2_end_lvl", fifo_lvl, 9'd0);
        check("t2_end_ovf", ovf_cnt, 8'd3);

        // 3: buffer while disabled, then release
        tx_en = 1'b0;
        push(32'hA1A2A3A4);
        push(32'h00FF00FF);
        push(32'hDEADBEEF);
        repeat (20) @(negedge clk_sys);
        check("t3_lvl_held", fifo_lvl, 9'd3);
        check("t3_tx_held", tx_bm, 1'b1);
        check("t3_busy_held", busy, 1'b0);
        tx_en = 1'b1;
        exp_w[0] = 32'hA1A2A3A4;
        exp_w[1] = 32'h00FF00FF;
        exp_w[2] = 32'hDEADBEEF;
        t_prev = 0;
        for (int k = 0; k < 3; k++) begin
            rx_packet(pkt, ok, t0);
            check("t3_frame", ok, 1'b1);
            check("t3_pkt", pkt, make_pkt(exp_w[k]));
            if (k > 0) check("t3_gap", t0 - t_prev, 240);
            t_prev = t0;
        end
        repeat (10) @(negedge clk_sys);
        check("t3_end_lvl", fifo_lvl, 9'd0);
        check("t3_end_busy", busy, 1'b0);

        // 4: asynchronous reset at byte 2, bit 4 (a 0 bit)
        push(32'h12003456);
        push(32'h77777777);
        check("t4_started", tx_bm, 1'b0);
        repeat (101) @(negedge clk_sys);
        check("t4_pre_tx", tx_bm, 1'b0);
        check("t4_pre_busy", busy, 1'b1);
        check("t4_pre_lvl", fifo_lvl, 9'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t4_rst_tx", tx_bm, 1'b1);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_rst_lvl", fifo_lvl, 9'd0);
        check("t4_rst_ovf", ovf_cnt, 8'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (tx_bm !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        check("t4_quiet_after", quiet, 1'b1);

        // 5: drop counter saturation
        tx_en = 1'b0;
        for (int i = 0; i < 270; i++) push(32'h5000_0000 + i);
        check("t5_lvl", fifo_lvl, 9'd16);
        check("t5_ovf_254", ovf_cnt, 8'd254);
        push(32'h5555_5555);
        check("t5_ovf_255", ovf_cnt, 8'd255);
        for (int i = 0; i < 45; i++) push(32'h6000_0000 + i);
        check("t5_ovf_hold", ovf_cnt, 8'd255);

        // 6: pushes into a full FIFO on pop edges
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
        for (int i = 0; i < 16; i++) push(32'hF00D_0000 + i);
        check("t6_full", fifo_lvl, 9'd16);
        bm_data = 32'hBEEF_0001;
        bm_vld  = 1'b1;
        tx_en   = 1'b1;
        @(negedge clk_sys);
        bm_vld  = 1'b0;
        check("t6_first_pushpop_lvl", fifo_lvl, 9'd16);
        check("t6_first_pushpop_ovf", ovf_cnt, 8'd0);
        rx_packet(pkt, ok, t0);
        check("t6_pkt0", pkt, make_pkt(32'hF00D_0000));
        repeat (2) @(negedge clk_sys);
        check("t6_full_before_stop", fifo_lvl, 9'd16);
        check("t6_busy_before_stop", busy, 1'b1);
        push(32'hBEEF_0002);
        check("t6_stop_pushpop_lvl", fifo_lvl, 9'd16);
        check("t6_stop_pushpop_ovf", ovf_cnt, 8'd0);
        for (int k = 0; k < 15; k++) exp_w[k] = 32'hF00D_0001 + k;
        exp_w[15] = 32'hBEEF_0001;
        exp_w[16] = 32'hBEEF_0002;
        t_prev = t0;
        for (int k = 0; k < 17; k++) begin
            rx_packet(pkt, ok, t0);
            check("t6_frame", ok, 1'b1);
            check("t6_pkt", pkt, make_pkt(exp_w[k]));
            check("t6_gap", t0 - t_prev, 240);
            t_prev = t0;
        end
        repeat (10) @(negedge clk_sys);
        check("t6_end_lvl", fifo_lvl, 9'd0);
        check("t6_end_busy", busy, 1'b0);
        check("t6_end_ovf", ovf_cnt, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
